atm_keypad_entry: RTL and testbench

- Keypad front-end that sits directly upstream of the ATM transaction controller.
- Turns single-key strobes into the 12-bit packed-nibble values that controller consumes: account number, PIN, and withdraw/deposit/transfer amount, destination account. Values are 3 nibbles, matching the hex database format.
- Handles backspace, clear, cancel and an inactivity timeout.
- Counts PIN rejections reported back by the controller and locks entry after too many failures.

---
 rtl/atm_keypad_entry_if.sv | 67 ++++++
 rtl/atm_keypad_entry.sv | 250 +++++++++++++++++++++++++
 tb/tb_atm_keypad_entry.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/atm_keypad_entry_if.sv
// Keypad-side bus for atm_keypad_entry. The echo signals exist only when
// KEYPAD_ECHO_EN is defined.
interface atm_keypad_entry_if;
   logic        start;
   logic [2:0]  field_id;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        pin_accept;
   logic        pin_reject;
   logic        busy;
   logic [11:0] value_out;
   logic [2:0]  value_field;
   logic        value_valid;
   logic        cancel_out;
   logic        timeout_out;
   logic [1:0]  digit_cnt;
   logic [2:0]  fail_cnt;
   logic        locked;
`ifdef KEYPAD_ECHO_EN
   logic [11:0] disp_digits;
   logic [1:0]  disp_cnt;
`endif

   modport master (
`ifdef KEYPAD_ECHO_EN
      input  disp_digits,
      input  disp_cnt,
`endif
      output start,
      output field_id,
      output key_valid,
      output key_code,
      output pin_accept,
      output pin_reject,
      input  busy,
      input  value_out,
      input  value_field,
      input  value_valid,
      input  cancel_out,
      input  timeout_out,
      input  digit_cnt,
      input  fail_cnt,
      input  locked
   );

   modport slave (
`ifdef KEYPAD_ECHO_EN
      output disp_digits,
      output disp_cnt,
`endif
      input  start,
      input  field_id,
      input  key_valid,
      input  key_code,
      input  pin_accept,
      input  pin_reject,
      output busy,
      output value_out,
      output value_field,
      output value_valid,
      output cancel_out,
      output timeout_out,
      output digit_cnt,
      output fail_cnt,
      output locked
   );
endinterface

// File: rtl/atm_keypad_entry.sv
// ATM keypad front-end: collects 3-nibble field values, tracks PIN failures and lockout.
// Optional masked display echo is enabled with the KEYPAD_ECHO_EN macro.
module atm_keypad_entry #(
   parameter int TIMEOUT_CYC = 1000,
   parameter int MAX_TRIES   = 3,
   parameter int CNT_W       = 10
) (
   input  logic               clk,
   input  logic               rst,
   atm_keypad_entry_if.slave  bus
);

   typedef enum logic [0:0] {
      S_IDLE    = 1'b0,
      S_COLLECT = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [2:0]       MAX_T     = 3'(MAX_TRIES);
   localparam logic [2:0]       FIELD_PIN = 3'd1;
   localparam logic [3:0]       K_ENTER   = 4'hA;
   localparam logic [3:0]       K_CLEAR   = 4'hB;
   localparam logic [3:0]       K_CANCEL  = 4'hC;
   localparam logic [3:0]       K_BKSP    = 4'hD;

   state_t           state_r, state_n;
   logic [2:0]       field_r, field_n;
   logic [11:0]      shift_r, shift_n;
   logic [1:0]       cnt_r, cnt_n;
   logic [CNT_W-1:0] timer_r, timer_n;
   logic [11:0]      value_r, value_n;
   logic [2:0]       vfield_r, vfield_n;
   logic             vv_r, vv_n;
   logic             can_r, can_n;
   logic             to_r, to_n;
   logic             busy_r;
   logic [2:0]       fail_r, fail_n;
   logic             locked_r, locked_n;
   logic             lock_set_s;
   logic             key_hit_s;

   // PIN needs all three digits; every other field needs at least one.
   function automatic logic enter_ok(input logic [2:0] fld, input logic [1:0] cnt);
      logic ok;
      if (fld == FIELD_PIN) begin
         ok = (cnt == 2'd3);
      end else begin
         ok = (cnt != 2'd0);
      end
      return ok;
   endfunction

   // E/F strobes are treated as if no key arrived at all.
   assign key_hit_s  = bus.key_valid && (bus.key_code < 4'hE);
   assign lock_set_s = locked_n && !locked_r;

   // Failure counter: reject wins over accept, accept cannot unlock.
   always_comb begin
      fail_n   = fail_r;
      locked_n = locked_r;
      if (bus.pin_reject) begin
         if (fail_r < MAX_T) begin
            fail_n = fail_r + 3'd1;
         end else begin
            fail_n = fail_r;
         end
      end else if (bus.pin_accept && !locked_r) begin
         fail_n = 3'd0;
      end else begin
         fail_n = fail_r;
      end
      if (fail_n == MAX_T) begin
         locked_n = 1'b1;
      end else begin
         locked_n = locked_r;
      end
   end

   // Entry FSM next-state and datapath.
   always_comb begin
      state_n  = state_r;
      field_n  = field_r;
      shift_n  = shift_r;
      cnt_n    = cnt_r;
      timer_n  = timer_r;
      value_n  = value_r;
      vfield_n = vfield_r;
      vv_n     = 1'b0;
      can_n    = 1'b0;
      to_n     = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (bus.start && !locked_r && !lock_set_s) begin
               state_n = S_COLLECT;
               field_n = bus.field_id;
               shift_n = 12'h000;
               cnt_n   = 2'd0;
               timer_n = {CNT_W{1'b0}};
            end else begin
               state_n = S_IDLE;
            end
         end
         S_COLLECT: begin
            if (lock_set_s) begin
               state_n = S_IDLE;
               shift_n = 12'h000;
               cnt_n   = 2'd0;
               can_n   = 1'b1;
            end else if (key_hit_s) begin
               timer_n = {CNT_W{1'b0}};
               case (bus.key_code)
                  K_ENTER: begin
                     if (enter_ok(field_r, cnt_r)) begin
                        value_n  = shift_r;
                        vfield_n = field_r;
                        vv_n     = 1'b1;
                        state_n  = S_IDLE;
                        shift_n  = 12'h000;
                        cnt_n    = 2'd0;
                     end else begin
                        state_n = S_COLLECT;
                     end
                  end
                  K_CLEAR: begin
                     shift_n = 12'h000;
                     cnt_n   = 2'd0;
                  end
                  K_CANCEL: begin
                     state_n = S_IDLE;
                     shift_n = 12'h000;
                     cnt_n   = 2'd0;
                     can_n   = 1'b1;
                  end
                  K_BKSP: begin
                     if (cnt_r != 2'd0) begin
                        shift_n = {4'h0, shift_r[11:4]};
                        cnt_n   = cnt_r - 2'd1;
                     end else begin
                        cnt_n = cnt_r;
                     end
                  end
                  4'h0, 4'h1, 4'h2, 4'h3, 4'h4,
                  4'h5, 4'h6, 4'h7, 4'h8, 4'h9: begin
                     if (cnt_r != 2'd3) begin
                        shift_n = {shift_r[7:0], bus.key_code};
                        cnt_n   = cnt_r + 2'd1;
                     end else begin
                        cnt_n = cnt_r;
                     end
                  end
                  default: begin
                     state_n = S_COLLECT;
                  end
               endcase
            end else if (timer_r == TMO_LAST) begin
               state_n = S_IDLE;
               shift_n = 12'h000;
               cnt_n   = 2'd0;
               to_n    = 1'b1;
            end else begin
               timer_n = timer_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= S_IDLE;
         field_r  <= 3'd0;
         shift_r  <= 12'h000;
         cnt_r    <= 2'd0;
         timer_r  <= {CNT_W{1'b0}};
         value_r  <= 12'h000;
         vfield_r <= 3'd0;
         vv_r     <= 1'b0;
         can_r    <= 1'b0;
         to_r     <= 1'b0;
         busy_r   <= 1'b0;
         fail_r   <= 3'd0;
         locked_r <= 1'b0;
      end else begin
         state_r  <= state_n;
         field_r  <= field_n;
         shift_r  <= shift_n;
         cnt_r    <= cnt_n;
         timer_r  <= timer_n;
         value_r  <= value_n;
         vfield_r <= vfield_n;
         vv_r     <= vv_n;
         can_r    <= can_n;
         to_r     <= to_n;
         busy_r   <= (state_n == S_COLLECT);
         fail_r   <= fail_n;
         locked_r <= locked_n;
      end
   end

   assign bus.busy        = busy_r;
   assign bus.value_out   = value_r;
   assign bus.value_field = vfield_r;
   assign bus.value_valid = vv_r;
   assign bus.cancel_out  = can_r;
   assign bus.timeout_out = to_r;
   assign bus.digit_cnt   = cnt_r;
   assign bus.fail_cnt    = fail_r;
   assign bus.locked      = locked_r;

`ifdef KEYPAD_ECHO_EN
   logic [11:0] disp_digits_r;
   logic [1:0]  disp_cnt_r;

   // Held nibbles are shown as-is, or as F when the field is a PIN.
   function automatic logic [11:0] echo_view(input logic [11:0] d, input logic [1:0] c,
                                             input logic pin);
      logic [11:0] view;
      view = 12'h000;
      for (int i = 0; i < 3; i++) begin
         if (i < int'(c)) begin
            view[4*i +: 4] = pin ? 4'hF : d[4*i +: 4];
         end else begin
            view[4*i +: 4] = 4'h0;
         end
      end
      return view;
   endfunction

   // Display mirror follows the next entry state so it lines up with digit_cnt.
   always_ff @(posedge clk) begin
      if (rst) begin
         disp_digits_r <= 12'h000;
         disp_cnt_r    <= 2'd0;
      end else if (state_n == S_COLLECT) begin
         disp_digits_r <= echo_view(shift_n, cnt_n, field_n == FIELD_PIN);
         disp_cnt_r    <= cnt_n;
      end else begin
         disp_digits_r <= 12'h000;
         disp_cnt_r    <= 2'd0;
      end
   end

   assign bus.disp_digits = disp_digits_r;
   assign bus.disp_cnt    = disp_cnt_r;
`endif

endmodule

// File: tb/tb_atm_keypad_entry.sv
// Table-driven bench for atm_keypad_entry with a commit scoreboard.
module tb_atm_keypad_entry;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   atm_keypad_entry_if bus();

   atm_keypad_entry #(.TIMEOUT_CYC(16), .MAX_TRIES(3), .CNT_W(10)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      logic        rs;
      logic        st;
      logic [2:0]  fid;
      logic        kv;
      logic [3:0]  kc;
      logic        acc;
      logic        rej;
      logic        busy;
      logic [1:0]  cnt;
      logic        vv;
      logic        can;
      logic        to;
      logic [2:0]  fail;
      logic        lock;
      logic        chk_v;
      logic [11:0] val;
      logic [2:0]  fld;
   } vec_t;

   typedef struct {
      logic [11:0] val;
      logic [2:0]  fld;
   } commit_t;

   vec_t    vecs[$];
   commit_t sb[$];
   int      checks = 0;
   int      failures = 0;
   logic [2:0] exp_fail = 3'd0;
   logic       exp_lock = 1'b0;

   function automatic void add(input logic rs, input logic st, input logic [2:0] fid,
                               input logic kv, input logic [3:0] kc, input logic acc,
                               input logic rej, input logic busy, input logic [1:0] cnt,
                               input logic vv, input logic can, input logic to);
      vec_t v;
      v.rs = rs; v.st = st; v.fid = fid; v.kv = kv; v.kc = kc; v.acc = acc; v.rej = rej;
      v.busy = busy; v.cnt = cnt; v.vv = vv; v.can = can; v.to = to;
      v.fail = exp_fail; v.lock = exp_lock;
      v.chk_v = 1'b0; v.val = 12'h000; v.fld = 3'd0;
      vecs.push_back(v);
   endfunction

   function automatic void k(input logic [3:0] kc, input logic busy, input logic [1:0] cnt);
      add(1'b0, 1'b0, 3'd0, 1'b1, kc, 1'b0, 1'b0, busy, cnt, 1'b0, 1'b0, 1'b0);
   endfunction

   function automatic void s(input logic [2:0] fid, input logic busy);
      add(1'b0, 1'b1, fid, 1'b0, 4'h0, 1'b0, 1'b0, busy, 2'd0, 1'b0, 1'b0, 1'b0);
   endfunction

   function automatic void idle(input logic busy, input logic [1:0] cnt, input logic to);
      add(1'b0, 1'b0, 3'd0, 1'b0, 4'h0, 1'b0, 1'b0, busy, cnt, 1'b0, 1'b0, to);
   endfunction

   function automatic void cancel_key();
      add(1'b0, 1'b0, 3'd0, 1'b1, 4'hC, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
   endfunction

   function automatic void pin(input logic acc, input logic rej);
      add(1'b0, 1'b0, 3'd0, 1'b0, 4'h0, acc, rej, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
   endfunction

   function automatic void reset_row();
      exp_fail = 3'd0;
      exp_lock = 1'b0;
      add(1'b1, 1'b0, 3'd0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      chk(12'h000, 3'd0);
   endfunction

   function automatic void chk(input logic [11:0] val, input logic [2:0] fld);
      vecs[vecs.size()-1].chk_v = 1'b1;
      vecs[vecs.size()-1].val   = val;
      vecs[vecs.size()-1].fld   = fld;
   endfunction

   function automatic void ent(input logic [11:0] val, input logic [2:0] fld);
      add(1'b0, 1'b0, 3'd0, 1'b1, 4'hA, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
      chk(val, fld);
   endfunction

   // Commit scoreboard: every value_valid pulse must match the oldest expected commit.
   always @(negedge clk) begin
      if (bus.value_valid === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL commit: unexpected value_valid value=%h field=%0d",
                     bus.value_out, bus.value_field);
         end else begin
            commit_t c;
            c = sb.pop_front();
            if (bus.value_out !== c.val || bus.value_field !== c.fld) begin
               failures++;
               $display("FAIL commit: got value=%h field=%0d want value=%h field=%0d",
                        bus.value_out, bus.value_field, c.val, c.fld);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] act;
      logic [9:0] exp;
      rst = 1'b1;
      bus.start = 1'b0; bus.field_id = 3'd0; bus.key_valid = 1'b0; bus.key_code = 4'h0;
      bus.pin_accept = 1'b0; bus.pin_reject = 1'b0;

      // Reset state, account entry
      reset_row();
      s(3'd0, 1'b1); k(4'h1, 1'b1, 2'd1); k(4'h2, 1'b1, 2'd2); k(4'h3, 1'b1, 2'd3);
      ent(12'h123, 3'd0); idle(1'b0, 2'd0, 1'b0);
      // Backspace and overflow
      s(3'd2, 1'b1); k(4'h5, 1'b1, 2'd1); k(4'h0, 1'b1, 2'd2); k(4'h0, 1'b1, 2'd3);
      k(4'h7, 1'b1, 2'd3); k(4'hD, 1'b1, 2'd2); k(4'h9, 1'b1, 2'd3);
      ent(12'h509, 3'd2);
      // PIN needs three digits
      s(3'd1, 1'b1); k(4'h4, 1'b1, 2'd1); k(4'h2, 1'b1, 2'd2); k(4'hA, 1'b1, 2'd2);
      k(4'h7, 1'b1, 2'd3); ent(12'h427, 3'd1);
      // E ignored, CLEAR, start while collecting ignored
      s(3'd3, 1'b1); k(4'hE, 1'b1, 2'd0); k(4'h6, 1'b1, 2'd1); k(4'hB, 1'b1, 2'd0);
      k(4'h8, 1'b1, 2'd1);
      add(1'b0, 1'b1, 3'd5, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
      ent(12'h008, 3'd3);
      // Backspace at zero, rejected ENTER, cancel keeps value_out
      s(3'd4, 1'b1); k(4'hD, 1'b1, 2'd0); k(4'hA, 1'b1, 2'd0); cancel_key();
      chk(12'h008, 3'd3);
      s(3'd0, 1'b1); k(4'h8, 1'b1, 2'd1); k(4'h8, 1'b1, 2'd2); cancel_key();
      chk(12'h008, 3'd3);
      k(4'h5, 1'b0, 2'd0);
      // Reset mid-entry
      s(3'd2, 1'b1); k(4'h3, 1'b1, 2'd1); reset_row(); idle(1'b0, 2'd0, 1'b0);
      // Failure counting, reject wins, lock while collecting
      exp_fail = 3'd1; pin(1'b0, 1'b1);
      exp_fail = 3'd0; pin(1'b1, 1'b0);
      exp_fail = 3'd1; pin(1'b1, 1'b1);
      exp_fail = 3'd2; pin(1'b0, 1'b1);
      s(3'd1, 1'b1); k(4'h5, 1'b1, 2'd1);
      exp_fail = 3'd3; exp_lock = 1'b1;
      add(1'b0, 1'b0, 3'd0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
      s(3'd0, 1'b0); pin(1'b1, 1'b0); pin(1'b0, 1'b1);
      // Lockout from idle
      reset_row();
      exp_fail = 3'd1; pin(1'b0, 1'b1);
      exp_fail = 3'd2; pin(1'b0, 1'b1);
      exp_fail = 3'd3; exp_lock = 1'b1; pin(1'b0, 1'b1);
      s(3'd0, 1'b0); pin(1'b1, 1'b0);
      reset_row();
      // Inactivity timeout, then a late ENTER does nothing
      s(3'd0, 1'b1); k(4'h1, 1'b1, 2'd1);
      for (int i = 0; i < 15; i++) idle(1'b1, 2'd1, 1'b0);
      idle(1'b0, 2'd0, 1'b1);
      k(4'hA, 1'b0, 2'd0); idle(1'b0, 2'd0, 1'b0);
      // A key on the expiry cycle beats the timeout
      s(3'd0, 1'b1); k(4'h2, 1'b1, 2'd1);
      for (int i = 0; i < 15; i++) idle(1'b1, 2'd1, 1'b0);
      k(4'h3, 1'b1, 2'd2);
      for (int i = 0; i < 15; i++) idle(1'b1, 2'd2, 1'b0);
      idle(1'b0, 2'd0, 1'b1);

      repeat (2) @(posedge clk);
      for (int r = 0; r < vecs.size(); r++) begin
         @(negedge clk);
         rst = vecs[r].rs;
         bus.start = vecs[r].st; bus.field_id = vecs[r].fid;
         bus.key_valid = vecs[r].kv; bus.key_code = vecs[r].kc;
         bus.pin_accept = vecs[r].acc; bus.pin_reject = vecs[r].rej;
         if (vecs[r].vv) begin
            commit_t c;
            c.val = vecs[r].val;
            c.fld = vecs[r].fld;
            sb.push_back(c);
         end
         @(posedge clk);
         #1;
         act = {bus.busy, bus.digit_cnt, bus.value_valid, bus.cancel_out, bus.timeout_out,
                bus.fail_cnt, bus.locked};
         exp = {vecs[r].busy, vecs[r].cnt, vecs[r].vv, vecs[r].can, vecs[r].to,
                vecs[r].fail, vecs[r].lock};
         checks++;
         if (act !== exp) begin
            failures++;
            $display("FAIL row%0d status {busy,cnt,vv,can,to,fail,lock}: got %b want %b",
                     r, act, exp);
         end
         if (vecs[r].chk_v) begin
            checks++;
            if (bus.value_out !== vecs[r].val || bus.value_field !== vecs[r].fld) begin
               failures++;
               $display("FAIL row%0d value_out: got %h/%0d want %h/%0d", r,
                        bus.value_out, bus.value_field, vecs[r].val, vecs[r].fld);
            end
         end
      end
      @(negedge clk);
      rst = 1'b0; bus.start = 1'b0; bus.key_valid = 1'b0;
      bus.pin_accept = 1'b0; bus.pin_reject = 1'b0;
      @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL commit_drain: got %0d pending commits want 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
